fake_signal_sequencer: RTL and testbench

- Scheduler that drives the fake-signal injector's MODE, USE_FAKE_SHWR and USE_FAKE_MUON controls from a small programmed step table.
- Lets software run unattended test campaigns, for example 10 s of mode 3 shower pulses, then 5 s of muon pulses, then random mode 21.
- Before every step it inserts a MODE=0 reset window so the injector's delay counters and LFSR start from a known state.
- Sits between the AXI-lite register block (table writes, START/STOP) and the fake-signal injector, in the injector's clock domain.

---
 rtl/fake_signal_pkg.sv | 35 +++
 rtl/fake_signal_sequencer_if.sv | 30 +++
 rtl/fss_tick_timer.sv | 47 ++++
 rtl/fake_signal_sequencer.sv | 140 ++++++++++++++
 tb/tb_fake_signal_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fake_signal_pkg.sv
// Shared definitions for the fake-signal sequencer: step-table entry layout,
// FSM state encoding and clock-rate constants.
package fake_signal_pkg;

    // Injector clock in MHz; one duration tick is 1 ms at this rate.
    localparam int unsigned CLOCK_FREQ = 120;

    // Bit positions of the fields inside a 32-bit table write word.
    localparam int unsigned MODE_LSB = 0;
    localparam int unsigned MODE_MSB = 4;
    localparam int unsigned SHWR_BIT = 5;
    localparam int unsigned MUON_BIT = 6;
    localparam int unsigned LAST_BIT = 7;
    localparam int unsigned DUR_LSB  = 16;
    localparam int unsigned DUR_MSB  = 31;

    localparam int unsigned MODE_W = MODE_MSB - MODE_LSB + 1;
    localparam int unsigned DUR_W  = DUR_MSB - DUR_LSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RSTWIN = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Stored form of one step; reserved write bits are dropped.
    typedef struct packed {
        logic [DUR_W-1:0]  dur;
        logic              last;
        logic              muon;
        logic              shwr;
        logic [MODE_W-1:0] mode;
    } entry_t;

endpackage

// File: rtl/fake_signal_sequencer_if.sv
// Bus between the register block (table writes, START/STOP) and the
// sequencer, plus the injector control outputs.
interface fake_signal_sequencer_if
    import fake_signal_pkg::*;
#(
    parameter int unsigned IDX_BITS = 3
);
    logic                WR_EN;
    logic [IDX_BITS-1:0] WR_ADDR;
    logic [31:0]         WR_DATA;
    logic                START;
    logic                STOP;
    logic                LOOP_EN;
    logic [MODE_W-1:0]   MODE;
    logic                USE_FAKE_SHWR;
    logic                USE_FAKE_MUON;
    logic                BUSY;
    logic [IDX_BITS-1:0] STEP_IDX;
    logic                SEQ_DONE;

    modport master (
        output WR_EN, WR_ADDR, WR_DATA, START, STOP, LOOP_EN,
        input  MODE, USE_FAKE_SHWR, USE_FAKE_MUON, BUSY, STEP_IDX, SEQ_DONE
    );

    modport slave (
        input  WR_EN, WR_ADDR, WR_DATA, START, STOP, LOOP_EN,
        output MODE, USE_FAKE_SHWR, USE_FAKE_MUON, BUSY, STEP_IDX, SEQ_DONE
    );
endinterface

// File: rtl/fss_tick_timer.sv
// Step duration timer: prescaler dividing the clock into ticks and a tick
// counter compared against the step duration. Held cleared while restart_i.
module fss_tick_timer
    import fake_signal_pkg::*;
#(
    parameter int unsigned TICK_DIV = CLOCK_FREQ * 1000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             restart_i,
    input  logic [DUR_W-1:0] duration_i,
    output logic             done_o
);
    localparam int unsigned     PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [DUR_W-1:0] tick_q, tick_d;
    logic             wrap;

    // Next-state: prescaler wraps every TICK_DIV cycles and bumps the tick count.
    always_comb begin
        wrap    = (presc_q == PRESC_LAST);
        presc_d = wrap ? '0 : presc_q + 1'b1;
        tick_d  = wrap ? tick_q + 1'b1 : tick_q;
        if (restart_i) begin
            presc_d = '0;
            tick_d  = '0;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            tick_q  <= '0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    // Done on the last cycle of the final tick; duration 0 never completes.
    assign done_o = !restart_i && (duration_i != '0) && wrap
                    && (tick_q == duration_i - 1'b1);

endmodule

// File: rtl/fake_signal_sequencer.sv
// Step-table scheduler driving the fake-signal injector's MODE and USE_FAKE_*
// controls, inserting a MODE=0 reset window before every step.
module fake_signal_sequencer
    import fake_signal_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned IDX_BITS     = 3,
    parameter int unsigned TICK_DIV     = CLOCK_FREQ * 1000,
    parameter int unsigned RESET_CYCLES = 4
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    fake_signal_sequencer_if.slave  bus
);
    localparam int unsigned         WIN_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [WIN_W-1:0]    WIN_LAST = WIN_W'(RESET_CYCLES - 1);
    localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(DEPTH - 1);

    entry_t              table_q [DEPTH];
    entry_t              wr_entry;
    entry_t              cur_entry;
    logic                unused_rsvd;

    state_t              state_q;
    logic [IDX_BITS-1:0] idx_q;
    logic [WIN_W-1:0]    win_q;
    logic                run_last_q;
    logic [DUR_W-1:0]    run_dur_q;
    logic [MODE_W-1:0]   mode_q;
    logic                shwr_q, muon_q, busy_q, done_q;
    logic                step_done;

    assign wr_entry = '{
        dur:  bus.WR_DATA[DUR_MSB:DUR_LSB],
        last: bus.WR_DATA[LAST_BIT],
        muon: bus.WR_DATA[MUON_BIT],
        shwr: bus.WR_DATA[SHWR_BIT],
        mode: bus.WR_DATA[MODE_MSB:MODE_LSB]
    };
    assign unused_rsvd = ^bus.WR_DATA[DUR_LSB-1:LAST_BIT+1];
    assign cur_entry   = table_q[idx_q];

    // Step table: writable in any state, visible the cycle after WR_EN.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int unsigned i = 0; i < DEPTH; i++) table_q[i] <= '0;
        end else if (bus.WR_EN) begin
            table_q[bus.WR_ADDR] <= wr_entry;
        end
    end

    fss_tick_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk_i      (CLK),
        .rst_ni     (RESETN),
        .restart_i  (state_q != ST_RUN),
        .duration_i (run_dur_q),
        .done_o     (step_done)
    );

    // Sequencer FSM with registered injector outputs; STOP overrides everything.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            win_q      <= '0;
            run_last_q <= 1'b0;
            run_dur_q  <= '0;
            mode_q     <= '0;
            shwr_q     <= 1'b0;
            muon_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.STOP) begin
                state_q <= ST_IDLE;
                mode_q  <= '0;
                shwr_q  <= 1'b0;
                muon_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.START) begin
                            state_q <= ST_RSTWIN;
                            idx_q   <= '0;
                            win_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_RSTWIN: begin
                        if (win_q == WIN_LAST) begin
                            state_q    <= ST_RUN;
                            run_last_q <= cur_entry.last;
                            run_dur_q  <= cur_entry.dur;
                            mode_q     <= cur_entry.mode;
                            shwr_q     <= cur_entry.shwr;
                            muon_q     <= cur_entry.muon;
                        end else begin
                            win_q <= win_q + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (step_done) begin
                            mode_q <= '0;
                            shwr_q <= 1'b0;
                            muon_q <= 1'b0;
                            win_q  <= '0;
                            if (!run_last_q && (idx_q != IDX_LAST)) begin
                                state_q <= ST_RSTWIN;
                                idx_q   <= idx_q + 1'b1;
                            end else if (bus.LOOP_EN) begin
                                state_q <= ST_RSTWIN;
                                idx_q   <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.MODE          = mode_q;
    assign bus.USE_FAKE_SHWR = shwr_q;
    assign bus.USE_FAKE_MUON = muon_q;
    assign bus.BUSY          = busy_q;
    assign bus.STEP_IDX      = idx_q;
    assign bus.SEQ_DONE      = done_q;

endmodule

// File: tb/tb_fake_signal_sequencer.sv
// Self-checking bench for fake_signal_sequencer: every cycle the outputs are
// compared against a step-list model that expands the programmed table into
// the expected per-cycle output stream.
module tb_fake_signal_sequencer;
    import fake_signal_pkg::*;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned IDX_BITS = 3;
    localparam int unsigned TD       = 10;
    localparam int unsigned RC       = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fake_signal_sequencer_if #(.IDX_BITS(IDX_BITS)) bus ();

    fake_signal_sequencer #(
        .DEPTH        (DEPTH),
        .IDX_BITS     (IDX_BITS),
        .TICK_DIV     (TD),
        .RESET_CYCLES (RC)
    ) dut (
        .CLK    (clk),
        .RESETN (rst_n),
        .bus    (bus)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Observation word: {done, busy, idx[2:0], muon, shwr, mode[4:0]}
    function automatic logic [11:0] obs();
        return {bus.SEQ_DONE, bus.BUSY, bus.STEP_IDX, bus.USE_FAKE_MUON,
                bus.USE_FAKE_SHWR, bus.MODE};
    endfunction

    function automatic logic [11:0] mk(input logic done, input logic busy, input logic [2:0] idx,
                                       input logic muon, input logic shwr, input logic [4:0] mode);
        return {done, busy, idx, muon, shwr, mode};
    endfunction

    // Reference model: table copy plus a queue of expected output words.
    logic [4:0]  m_mode [DEPTH];
    logic        m_shwr [DEPTH];
    logic        m_muon [DEPTH];
    logic        m_last [DEPTH];
    int unsigned m_dur  [DEPTH];
    logic [11:0] exp_q [$];
    int unsigned m_phase;
    bit          m_active, m_inf, m_run_last;
    logic [11:0] m_inf_item, m_cur;
    int unsigned m_next, m_run_idx;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mode[i] = '0; m_shwr[i] = 0; m_muon[i] = 0; m_last[i] = 0; m_dur[i] = 0;
        end
        exp_q.delete();
        m_active = 0; m_inf = 0; m_cur = '0; m_phase = 0; m_next = 0;
    endtask

    task automatic model_write(input logic [2:0] a, input logic [31:0] d);
        m_mode[a] = d[4:0];
        m_shwr[a] = d[5];
        m_muon[a] = d[6];
        m_last[a] = d[7];
        m_dur[a]  = d[31:16];
    endtask

    // Phase 0: reset window, 1: run segment from the table as it is now,
    // 2: decide what follows the finished step.
    task automatic model_advance();
        logic [11:0] item;
        case (m_phase)
            0: begin
                repeat (RC) exp_q.push_back(mk(0, 1, 3'(m_next), 0, 0, 5'd0));
                m_phase = 1;
            end
            1: begin
                m_run_idx  = m_next;
                m_run_last = m_last[m_next];
                item = mk(0, 1, 3'(m_next), m_muon[m_next], m_shwr[m_next], m_mode[m_next]);
                if (m_dur[m_next] == 0) begin
                    m_inf      = 1;
                    m_inf_item = item;
                end else begin
                    repeat (m_dur[m_next] * TD) exp_q.push_back(item);
                end
                m_phase = 2;
            end
            default: begin
                m_phase = 0;
                if (!m_run_last && m_run_idx < DEPTH - 1) m_next = m_run_idx + 1;
                else if (bus.LOOP_EN) m_next = 0;
                else begin
                    exp_q.push_back(mk(1, 0, 3'(m_run_idx), 0, 0, 5'd0));
                    m_active = 0;
                end
            end
        endcase
    endtask

    task automatic model_expect(output logic [11:0] e);
        while (exp_q.size() == 0 && !m_inf && m_active) model_advance();
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else if (m_inf)        e = m_inf_item;
        else                   e = mk(0, 0, m_cur[9:7], 0, 0, 5'd0);
    endtask

    // One clock: drive START/STOP (and any pending write), step the model, compare.
    task automatic step_cycle(input bit start, input bit stop, input string tag);
        logic [11:0] e;
        bus.START = start;
        bus.STOP  = stop;
        @(negedge clk);
        if (stop) begin
            exp_q.delete();
            m_inf = 0; m_active = 0; m_phase = 0;
            e = mk(0, 0, m_cur[9:7], 0, 0, 5'd0);
        end else begin
            if (start && !m_cur[10]) begin
                exp_q.delete();
                m_inf = 0; m_active = 1; m_phase = 0; m_next = 0;
            end
            model_expect(e);
        end
        m_cur = e;
        check_eq(tag, {20'd0, obs()}, {20'd0, e});
        // A write at this edge is invisible to a latch at the same edge.
        if (bus.WR_EN) model_write(bus.WR_ADDR, bus.WR_DATA);
        bus.START = 0;
        bus.STOP  = 0;
        bus.WR_EN = 0;
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) step_cycle(0, 0, tag);
    endtask

    task automatic set_wr(input int a, input logic [4:0] mode, input bit shwr, input bit muon,
                          input bit last, input int unsigned dur);
        bus.WR_EN   = 1;
        bus.WR_ADDR = 3'(a);
        bus.WR_DATA = {16'(dur), 8'($urandom), last, muon, shwr, mode};
    endtask

    task automatic wr(input int a, input logic [4:0] mode, input bit shwr, input bit muon,
                      input bit last, input int unsigned dur);
        set_wr(a, mode, shwr, muon, last, dur);
        step_cycle(0, 0, "wr");
    endtask

    int unsigned cnt;
    int unsigned p;

    initial begin
        bus.WR_EN = 0; bus.WR_ADDR = '0; bus.WR_DATA = '0;
        bus.START = 0; bus.STOP = 0; bus.LOOP_EN = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("in_reset", {20'd0, obs()}, 32'd0);
        rst_n = 1;
        step_cycle(0, 0, "reset_rel");

        // Two-step table, single pass.
        wr(0, 5'd3, 1, 0, 0, 2);
        wr(1, 5'd6, 0, 1, 1, 1);
        step_cycle(1, 0, "t1_start");
        cnt = 0;
        for (int c = 0; c < 42; c++) begin
            step_cycle(0, 0, "t1_run");
            cnt += bus.SEQ_DONE;
        end
        check_eq("t1_done_cnt", cnt, 1);
        check_eq("t1_idx", bus.STEP_IDX, 1);
        check_eq("t1_busy", bus.BUSY, 0);

        // Looping, with entry 0 rewritten during its own run, then STOP.
        bus.LOOP_EN = 1;
        step_cycle(1, 0, "loop_start");
        run(9, "loop_run");
        wr(0, 5'd9, 0, 1, 0, 2);
        run(40, "loop_run");
        check_eq("loop_idx", bus.STEP_IDX, 0);
        check_eq("loop_mode", bus.MODE, 9);
        step_cycle(0, 1, "loop_stop");
        check_eq("loop_stop_busy", bus.BUSY, 0);
        run(3, "loop_idle");
        bus.LOOP_EN = 0;

        // Indefinite step.
        wr(0, 5'd21, 1, 1, 0, 0);
        step_cycle(1, 0, "d0_start");
        run(1000, "d0_run");
        step_cycle(0, 1, "d0_stop");
        run(2, "d0_idle");

        // All entries without LAST: ends after entry 7; START while busy ignored.
        for (int i = 0; i < DEPTH; i++) wr(i, 5'($urandom), 1'($urandom), 1'($urandom), 0, 1);
        step_cycle(1, 0, "all8_start");
        run(30, "all8_run");
        step_cycle(1, 0, "busy_start");
        run(88, "all8_run");
        check_eq("all8_idx", bus.STEP_IDX, 7);

        // START and STOP together from IDLE.
        step_cycle(1, 1, "start_stop");
        run(3, "ss_idle");

        // Randomized campaigns.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++)
                wr(i, 5'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3));
            bus.LOOP_EN = ($urandom_range(0, 3) == 0);
            step_cycle(1, 0, "rnd_start");
            for (int c = 0; c < 200; c++) begin
                p = $urandom_range(0, 99);
                if (p < 8) begin
                    set_wr($urandom_range(0, DEPTH - 1), 5'($urandom), 1'($urandom), 1'($urandom),
                           ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
                    step_cycle(0, 0, "rnd_wr");
                end else if (p < 10) step_cycle(1, 0, "rnd_restart");
                else if (p < 11)     step_cycle(0, 1, "rnd_stop");
                else                 step_cycle(0, 0, "rnd");
            end
            step_cycle(0, 1, "rnd_end");
            bus.LOOP_EN = 0;
        end

        // Asynchronous reset in RUN clears outputs and table without a clock edge.
        wr(0, 5'd5, 1, 0, 0, 3);
        step_cycle(1, 0, "ar_start");
        run(10, "ar_run");
        #2 rst_n = 0;
        #1 check_eq("async_rst", {20'd0, obs()}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        run(2, "post_rst");
        step_cycle(1, 0, "cleared_start");
        run(8, "cleared_run");
        step_cycle(0, 1, "cleared_stop");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
